mem_requester: RTL and testbench

- Initiator side of the synchronous data-RAM port: memory enable, write strobe, read strobe, address, write data, and read data with one-cycle registered latency.
- Accepts load/store requests from the processor datapath over a valid/ready handshake and buffers them in a small in-order FIFO.
- Drives the RAM strobes from registers and returns load data as a one-cycle response pulse.
- Sits between the datapath's load/store stage and the data memory.

---
 rtl/mem_req_pkg.sv | 37 +++
 rtl/mem_requester_fifo.sv | 71 +++++++
 rtl/mem_requester.sv | 172 +++++++++++++++++
 tb/tb_mem_requester.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_req_pkg.sv
// mem_req_pkg: shared definitions for the data-RAM requester.
//
// Request entry layout (MSB..LSB): {write, adr, wdata}
//   wdata : bits [WIDTH-1:0]
//   adr   : bits [WIDTH +: RAM_ADDR_BITS]
//   write : bit  [WIDTH + RAM_ADDR_BITS]
// The widths are module parameters, so the entry width and field offsets
// are provided as constant functions that the requester evaluates for
// its own WIDTH / RAM_ADDR_BITS.
package mem_req_pkg;

  // The RAM returns read data one edge after it samples the strobes.
  localparam int RD_LAT = 1;

  // Read-pending tags: one stage for the strobe cycle plus RD_LAT stages
  // for the RAM, so the capture lines up with valid mem_rdata.
  localparam int PEND_STAGES = RD_LAT + 1;

  // Offset of the write-data field inside an entry.
  localparam int OFF_WDATA = 0;

  // Total entry width: write flag + address + data.
  function automatic int req_w(input int adr_bits, input int data_bits);
    return 1 + adr_bits + data_bits;
  endfunction

  // Offset of the address field.
  function automatic int off_adr(input int data_bits);
    return OFF_WDATA + data_bits;
  endfunction

  // Offset of the write flag.
  function automatic int off_write(input int adr_bits, input int data_bits);
    return OFF_WDATA + data_bits + adr_bits;
  endfunction

endpackage

// File: rtl/mem_requester_fifo.sv
// req_fifo: small in-order request buffer with registered storage.
//
// Ports:
//   clk, reset_n       clock, asynchronous active-low reset
//   i_push, i_push_data write one entry (ignored while full, even if a pop
//                      happens in the same cycle)
//   i_pop              drop the head entry (ignored while empty)
//   o_pop_data         head entry (valid while !o_empty)
//   o_full, o_empty    status flags
//   o_count            number of stored entries, one bit wider than the
//                      pointers so full and empty are distinguishable
//
// DEPTH must be a power of two (>= 2) so pointers wrap naturally.
module req_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_push_data,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_pop_data,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;

  logic w_push_ok;
  logic w_pop_ok;

  assign o_full     = (r_count == FULL_CNT);
  assign o_empty    = (r_count == '0);
  assign o_count    = r_count;
  assign o_pop_data = r_mem[r_rd_ptr];

  // Full refuses a push outright; a simultaneous pop does not make room
  // until the following cycle.
  assign w_push_ok = i_push && !o_full;
  assign w_pop_ok  = i_pop && !o_empty;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage carries no reset; only entries between the pointers are read.
  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wr_ptr] <= i_push_data;
  end

endmodule

// File: rtl/mem_requester.sv
// mem_requester: initiator side of the synchronous data-RAM port.
//
// Load/store requests from the datapath are buffered in an in-order FIFO
// and issued one per cycle onto registered RAM strobes. Load data comes
// back from the RAM one edge after issue and is returned as a one-cycle
// rsp_valid pulse, strictly in request order. Stores produce no response.
//
// Handshake: a request is transferred at a rising edge where
// req_valid && req_ready are both high. req_ready = !full and never depends
// on req_valid. There is no response backpressure: rsp_data must be taken
// in the cycle rsp_valid is high (it then holds until the next pulse).
//
// Ports:
//   clk, reset_n                 clock, asynchronous active-low reset
//   req_valid/req_ready          request handshake
//   req_write, req_adr, req_wdata request fields (1 = store, 0 = load)
//   rsp_valid, rsp_data          load response pulse and data
//   mem_en/write/read/adr/wdata  registered RAM strobes and fields
//   mem_rdata                    RAM read data, valid one cycle after issue
//   busy                         work queued, issued or awaiting data
//   rd_count, wr_count           issued load/store counters
//                                (only with MEMREQ_PERF_EN defined)
//
// Optional feature macro: MEMREQ_PERF_EN
module mem_requester
  import mem_req_pkg::*;
#(
  parameter int WIDTH         = 16,
  parameter int RAM_ADDR_BITS = 16,
  parameter int DEPTH         = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_write,
  input  logic [RAM_ADDR_BITS-1:0] req_adr,
  input  logic [WIDTH-1:0]         req_wdata,
  output logic                     rsp_valid,
  output logic [WIDTH-1:0]         rsp_data,
  output logic                     mem_en,
  output logic                     mem_write,
  output logic                     mem_read,
  output logic [RAM_ADDR_BITS-1:0] mem_adr,
  output logic [WIDTH-1:0]         mem_wdata,
  input  logic [WIDTH-1:0]         mem_rdata,
  output logic                     busy
`ifdef MEMREQ_PERF_EN
  ,
  output logic [15:0]              rd_count,
  output logic [15:0]              wr_count
`endif
);

  localparam int REQ_W  = req_w(RAM_ADDR_BITS, WIDTH);
  localparam int OFF_A  = off_adr(WIDTH);
  localparam int OFF_WR = off_write(RAM_ADDR_BITS, WIDTH);
  localparam int CNT_W  = $clog2(DEPTH) + 1;

  logic             w_full;
  logic             w_empty;
  logic [CNT_W-1:0] w_count;
  logic [REQ_W-1:0] w_head;
  logic [REQ_W-1:0] w_in;
  logic [REQ_W-1:0] w_entry;
  logic             w_accept;
  logic             w_pop;
  logic             w_bypass;
  logic             w_fifo_push;
  logic             w_issue;
  logic             w_issue_write;
  logic             w_issue_hold;

  logic                     r_mem_en;
  logic                     r_mem_write;
  logic                     r_mem_read;
  logic [RAM_ADDR_BITS-1:0] r_mem_adr;
  logic [WIDTH-1:0]         r_mem_wdata;
  logic [PEND_STAGES-1:0]   r_rd_pend;
  logic                     r_rsp_valid;
  logic [WIDTH-1:0]         r_rsp_data;

  // Issue-stall hook: tied low in the design; lets a bench freeze issue
  // so the FIFO can be filled.
  assign w_issue_hold = 1'b0;

  assign w_in     = {req_write, req_adr, req_wdata};
  assign w_accept = req_valid && req_ready;

  // The head of a non-empty FIFO always goes first. When the FIFO is
  // empty an accepted request issues in the same edge it is accepted
  // (fall-through), which gives the 3-edge accept-to-response latency and
  // keeps order intact.
  assign w_pop       = !w_empty && !w_issue_hold;
  assign w_bypass    = w_empty && w_accept && !w_issue_hold;
  assign w_fifo_push = w_accept && !w_bypass;
  assign w_issue     = w_pop || w_bypass;
  assign w_entry     = w_pop ? w_head : w_in;
  assign w_issue_write = w_entry[OFF_WR];

  req_fifo #(
    .WIDTH (REQ_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .reset_n     (reset_n),
    .i_push      (w_fifo_push),
    .i_push_data (w_in),
    .i_pop       (w_pop),
    .o_pop_data  (w_head),
    .o_full      (w_full),
    .o_empty     (w_empty),
    .o_count     (w_count)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_mem_en    <= 1'b0;
      r_mem_write <= 1'b0;
      r_mem_read  <= 1'b0;
      r_mem_adr   <= '0;
      r_mem_wdata <= '0;
      r_rd_pend   <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
    end else begin
      r_mem_en    <= w_issue;
      r_mem_write <= w_issue && w_issue_write;
      r_mem_read  <= w_issue && !w_issue_write;
      // Address and data hold their last values while idle.
      if (w_issue) begin
        r_mem_adr   <= w_entry[OFF_A +: RAM_ADDR_BITS];
        r_mem_wdata <= w_entry[OFF_WDATA +: WIDTH];
      end
      // Bit 0 marks the strobe cycle of a load; the top bit marks the
      // cycle in which mem_rdata carries that load's data.
      r_rd_pend   <= {r_rd_pend[PEND_STAGES-2:0], w_issue && !w_issue_write};
      r_rsp_valid <= r_rd_pend[PEND_STAGES-1];
      if (r_rd_pend[PEND_STAGES-1]) r_rsp_data <= mem_rdata;
    end
  end

  assign req_ready = !w_full;
  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_data;
  assign mem_en    = r_mem_en;
  assign mem_write = r_mem_write;
  assign mem_read  = r_mem_read;
  assign mem_adr   = r_mem_adr;
  assign mem_wdata = r_mem_wdata;
  assign busy      = (w_count != '0) || r_mem_en || (|r_rd_pend);

`ifdef MEMREQ_PERF_EN
  logic [15:0] r_rd_count;
  logic [15:0] r_wr_count;

  // Free-running counters; they wrap from 16'hFFFF to 0.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rd_count <= '0;
      r_wr_count <= '0;
    end else if (w_issue) begin
      if (w_issue_write) r_wr_count <= r_wr_count + 16'd1;
      else               r_rd_count <= r_rd_count + 16'd1;
    end
  end

  assign rd_count = r_rd_count;
  assign wr_count = r_wr_count;
`endif

endmodule

// File: tb/tb_mem_requester.sv
// Directed bench for mem_requester with a behavioural synchronous RAM.
module tb_mem_requester;

  localparam int WIDTH = 16;
  localparam int AB    = 16;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             req_valid;
  logic             req_ready;
  logic             req_write;
  logic [AB-1:0]    req_adr;
  logic [WIDTH-1:0] req_wdata;
  logic             rsp_valid;
  logic [WIDTH-1:0] rsp_data;
  logic             mem_en;
  logic             mem_write;
  logic             mem_read;
  logic [AB-1:0]    mem_adr;
  logic [WIDTH-1:0] mem_wdata;
  logic [WIDTH-1:0] mem_rdata;
  logic             busy;
`ifdef MEMREQ_PERF_EN
  logic [15:0]      rd_count;
  logic [15:0]      wr_count;
`endif

  int checks = 0;
  int errors = 0;

  logic [WIDTH-1:0] exp_q[$];
  logic [WIDTH-1:0] ram [0:255];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  mem_requester #(.WIDTH(WIDTH), .RAM_ADDR_BITS(AB), .DEPTH(4)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_adr   (req_adr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .mem_en    (mem_en),
    .mem_write (mem_write),
    .mem_read  (mem_read),
    .mem_adr   (mem_adr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .busy      (busy)
`ifdef MEMREQ_PERF_EN
    ,
    .rd_count  (rd_count),
    .wr_count  (wr_count)
`endif
  );

  // Synchronous RAM: write and read sampled at the edge, read data
  // registered (valid the cycle after the strobe).
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_write) ram[mem_adr[7:0]] <= mem_wdata;
      if (mem_read)  mem_rdata <= ram[mem_adr[7:0]];
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic w, input logic [AB-1:0] a,
                       input logic [WIDTH-1:0] d);
    req_valid = v;
    req_write = w;
    req_adr   = a;
    req_wdata = d;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset_n = 1'b0;
    drive(1'b1, 1'b1, 16'h0055, 16'h1234);
    repeat (2) @(posedge clk);
    #1;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_req_ready: got %b want 1", req_ready); end
    checks++; if (mem_en !== 1'b0) begin errors++; $display("FAIL rst_mem_en: got %b want 0", mem_en); end
    checks++; if (mem_write !== 1'b0) begin errors++; $display("FAIL rst_mem_write: got %b want 0", mem_write); end
    checks++; if (mem_read !== 1'b0) begin errors++; $display("FAIL rst_mem_read: got %b want 0", mem_read); end
    checks++; if (mem_adr !== 16'h0) begin errors++; $display("FAIL rst_mem_adr: got %h want 0", mem_adr); end
    checks++; if (mem_wdata !== 16'h0) begin errors++; $display("FAIL rst_mem_wdata: got %h want 0", mem_wdata); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_rsp_valid: got %b want 0", rsp_valid); end
    checks++; if (rsp_data !== 16'h0) begin errors++; $display("FAIL rst_rsp_data: got %h want 0", rsp_data); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", busy); end
    reset_n = 1'b1;
    tick();  // first request accepted, strobes follow immediately
    checks++; if (mem_en !== 1'b1) begin errors++; $display("FAIL first_mem_en: got %b want 1", mem_en); end
    checks++; if (mem_write !== 1'b1) begin errors++; $display("FAIL first_mem_write: got %b want 1", mem_write); end
    checks++; if (mem_read !== 1'b0) begin errors++; $display("FAIL first_mem_read: got %b want 0", mem_read); end
    checks++; if (mem_adr !== 16'h0055) begin errors++; $display("FAIL first_mem_adr: got %h want 0055", mem_adr); end
    checks++; if (mem_wdata !== 16'h1234) begin errors++; $display("FAIL first_mem_wdata: got %h want 1234", mem_wdata); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL first_busy: got %b want 1", busy); end
    drive(1'b0, 1'b0, 16'h0, 16'h0);
    tick();
    checks++; if (mem_en !== 1'b0) begin errors++; $display("FAIL idle_mem_en: got %b want 0", mem_en); end
    checks++; if (mem_adr !== 16'h0055) begin errors++; $display("FAIL idle_hold_adr: got %h want 0055", mem_adr); end
    checks++; if (mem_wdata !== 16'h1234) begin errors++; $display("FAIL idle_hold_wdata: got %h want 1234", mem_wdata); end
  endtask

  task automatic test_store_load();
    drive(1'b1, 1'b1, 16'h0010, 16'hBEEF);
    tick();  // E0 -> C1
    checks++; if (mem_write !== 1'b1) begin errors++; $display("FAIL sl_c1_write: got %b want 1", mem_write); end
    checks++; if (mem_read !== 1'b0) begin errors++; $display("FAIL sl_c1_read: got %b want 0", mem_read); end
    checks++; if (mem_adr !== 16'h0010) begin errors++; $display("FAIL sl_c1_adr: got %h want 0010", mem_adr); end
    checks++; if (mem_wdata !== 16'hBEEF) begin errors++; $display("FAIL sl_c1_wdata: got %h want beef", mem_wdata); end
    drive(1'b1, 1'b0, 16'h0010, 16'h0000);
    tick();  // E1 -> C2
    checks++; if (mem_read !== 1'b1) begin errors++; $display("FAIL sl_c2_read: got %b want 1", mem_read); end
    checks++; if (mem_write !== 1'b0) begin errors++; $display("FAIL sl_c2_write: got %b want 0", mem_write); end
    drive(1'b0, 1'b0, 16'h0, 16'h0);
    tick();  // C3
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL sl_c3_rsp_valid: got %b want 0", rsp_valid); end
    tick();  // C4
    checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL sl_c4_rsp_valid: got %b want 1", rsp_valid); end
    checks++; if (rsp_data !== 16'hBEEF) begin errors++; $display("FAIL sl_c4_rsp_data: got %h want beef", rsp_data); end
    tick();  // C5
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL sl_c5_rsp_valid: got %b want 0", rsp_valid); end
    checks++; if (rsp_data !== 16'hBEEF) begin errors++; $display("FAIL sl_c5_rsp_hold: got %h want beef", rsp_data); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL sl_c5_busy: got %b want 0", busy); end
  endtask

  task automatic test_back_to_back();
    logic             exp_v;
    logic [WIDTH-1:0] exp_d;
    ram[0] = 16'h1111; ram[1] = 16'h2222; ram[2] = 16'h3333; ram[3] = 16'h4444;
    exp_q = {16'h1111, 16'h2222, 16'h3333, 16'h4444};
    for (int k = 1; k <= 8; k++) begin
      if (k <= 4) drive(1'b1, 1'b0, 16'(k - 1), 16'h0);
      else        drive(1'b0, 1'b0, 16'h0, 16'h0);
      tick();  // now in cycle C_k; load n was accepted at E_n
      exp_v = (k >= 3) && (k <= 6);
      checks++; if (rsp_valid !== exp_v) begin errors++; $display("FAIL b2b_rsp_valid_c%0d: got %b want %b", k, rsp_valid, exp_v); end
      if (exp_v) begin
        exp_d = exp_q.pop_front();
        checks++; if (rsp_data !== exp_d) begin errors++; $display("FAIL b2b_rsp_data_c%0d: got %h want %h", k, rsp_data, exp_d); end
      end
    end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL b2b_leftover: got %0d want 0", exp_q.size()); end
  endtask

  task automatic test_full_fifo();
    logic [AB-1:0] exp_a;
    force dut.w_issue_hold = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b1, 16'h0020 + 16'(i), 16'hA000 + 16'(i));
      checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL full_ready_before_%0d: got %b want 1", i, req_ready); end
      tick();
      checks++; if (mem_en !== 1'b0) begin errors++; $display("FAIL full_held_en_%0d: got %b want 0", i, mem_en); end
    end
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL full_ready_after4: got %b want 0", req_ready); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL full_busy: got %b want 1", busy); end
    drive(1'b1, 1'b1, 16'h0024, 16'hA004);
    tick();
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL full_5th_ready: got %b want 0", req_ready); end
    release dut.w_issue_hold;
    #1;
    // Pop happens at the coming edge; the push must still be refused.
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL full_pop_cycle_ready: got %b want 0", req_ready); end
    tick();
    checks++; if (mem_en !== 1'b1) begin errors++; $display("FAIL full_pop0_en: got %b want 1", mem_en); end
    checks++; if (mem_adr !== 16'h0020) begin errors++; $display("FAIL full_pop0_adr: got %h want 0020", mem_adr); end
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL full_ready_reopen: got %b want 1", req_ready); end
    tick();  // 5th accepted here while 0x21 issues
    checks++; if (mem_adr !== 16'h0021) begin errors++; $display("FAIL full_pop1_adr: got %h want 0021", mem_adr); end
    drive(1'b0, 1'b0, 16'h0, 16'h0);
    for (int i = 2; i <= 4; i++) begin
      exp_a = 16'h0020 + 16'(i);
      tick();
      checks++; if (mem_en !== 1'b1) begin errors++; $display("FAIL full_pop%0d_en: got %b want 1", i, mem_en); end
      checks++; if (mem_adr !== exp_a) begin errors++; $display("FAIL full_pop%0d_adr: got %h want %h", i, mem_adr, exp_a); end
      checks++; if (mem_wdata !== 16'hA000 + 16'(i)) begin errors++; $display("FAIL full_pop%0d_wdata: got %h want %h", i, mem_wdata, 16'hA000 + 16'(i)); end
    end
    tick();
    checks++; if (mem_en !== 1'b0) begin errors++; $display("FAIL full_drained_en: got %b want 0", mem_en); end
  endtask

  task automatic test_reset_midflight();
    ram[8'h30] = 16'h5A5A; ram[8'h31] = 16'hA5A5; ram[8'h32] = 16'h0F0F;
    drive(1'b1, 1'b0, 16'h0030, 16'h0);
    tick();  // E0 -> C1
    drive(1'b1, 1'b0, 16'h0031, 16'h0);
    tick();  // E1 -> C2
    drive(1'b1, 1'b0, 16'h0032, 16'h0);
    reset_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_busy_in_reset: got %b want 0", busy); end
    checks++; if (mem_en !== 1'b0) begin errors++; $display("FAIL mid_en_in_reset: got %b want 0", mem_en); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL mid_rsp_in_reset: got %b want 0", rsp_valid); end
    drive(1'b0, 1'b0, 16'h0, 16'h0);
    tick();
    tick();
    reset_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL mid_rsp_after_%0d: got %b want 0", k, rsp_valid); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_busy_after_%0d: got %b want 0", k, busy); end
    end
  endtask

`ifdef MEMREQ_PERF_EN
  task automatic test_perf();
    // Counters start from the reset of the previous scenario.
    drive(1'b1, 1'b0, 16'h0000, 16'h0); tick();
    drive(1'b1, 1'b1, 16'h0040, 16'h0001); tick();
    drive(1'b1, 1'b0, 16'h0001, 16'h0); tick();
    drive(1'b1, 1'b1, 16'h0041, 16'h0002); tick();
    drive(1'b1, 1'b0, 16'h0002, 16'h0); tick();
    drive(1'b0, 1'b0, 16'h0, 16'h0);
    repeat (4) tick();
    checks++; if (rd_count !== 16'd3) begin errors++; $display("FAIL perf_rd_count: got %0d want 3", rd_count); end
    checks++; if (wr_count !== 16'd2) begin errors++; $display("FAIL perf_wr_count: got %0d want 2", wr_count); end
    force dut.r_wr_count = 16'hFFFF;
    #1;
    release dut.r_wr_count;
    drive(1'b1, 1'b1, 16'h0042, 16'h0003); tick();
    drive(1'b0, 1'b0, 16'h0, 16'h0); tick();
    checks++; if (wr_count !== 16'h0000) begin errors++; $display("FAIL perf_wr_wrap: got %h want 0000", wr_count); end
    checks++; if (rd_count !== 16'd3) begin errors++; $display("FAIL perf_rd_after_wrap: got %0d want 3", rd_count); end
  endtask
`endif

  // ---------------- sequence + report ----------------
  initial begin
    for (int i = 0; i < 256; i++) ram[i] = '0;
    test_reset();
    test_store_load();
    test_back_to_back();
    test_full_fifo();
    test_reset_midflight();
`ifdef MEMREQ_PERF_EN
    test_perf();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
